// File: rtl/arbitro_vc_param_if.sv
// VC-side and destination-side signal bundle for arbitro_vc_param.
// master: FIFO/lane environment; slave: the arbiter.
interface arbitro_vc_param_if #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned NUM_VC   = 4,
  parameter int unsigned NUM_DEST = 2,
  parameter int unsigned WEIGHT_W = 3
);
  logic [NUM_VC*DATA_W-1:0]   VC_data;
  logic [NUM_VC-1:0]          VC_empty;
  logic [NUM_VC*WEIGHT_W-1:0] VC_weight;
  logic [NUM_DEST-1:0]        D_pause;
  logic [NUM_VC-1:0]          VC_pop;
  logic [NUM_DEST*DATA_W-1:0] D_data;
  logic [NUM_DEST-1:0]        D_valid;

  modport master (
    output VC_data, VC_empty, VC_weight, D_pause,
    input  VC_pop, D_data, D_valid
  );

  modport slave (
    input  VC_data, VC_empty, VC_weight, D_pause,
    output VC_pop, D_data, D_valid
  );
endinterface

// File: rtl/arbitro_vc_param.sv
// Parametrised VC arbiter: pops one word per cycle from an eligible VC and routes it to a registered lane.
// Policy: strict priority by default, weighted round-robin when ARB_WRR_EN is defined.
module arbitro_vc_param #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned NUM_VC   = 4,
  parameter int unsigned NUM_DEST = 2,
  parameter int unsigned DEST_LSB = 4,
  parameter int unsigned WEIGHT_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  arbitro_vc_param_if.slave    vc
);
  localparam int unsigned DEST_W = $clog2(NUM_DEST);
  localparam int unsigned PTR_W  = $clog2(NUM_VC);

  logic [DEST_W-1:0]          dest_of [NUM_VC];
  logic [NUM_VC-1:0]          eligible;
  logic                       grant_valid;
  logic [PTR_W-1:0]           grant_idx;
  logic [DATA_W-1:0]          grant_data;
  logic [DEST_W-1:0]          grant_dest;
  logic [NUM_DEST*DATA_W-1:0] d_data_q;
  logic [NUM_DEST-1:0]        d_valid_q;

  // A VC competes only if it has a word and its destination is not paused.
  always_comb begin : eligibility
    for (int i = 0; i < NUM_VC; i++) begin
      dest_of[i]  = vc.VC_data[i*DATA_W + DEST_LSB +: DEST_W];
      eligible[i] = !vc.VC_empty[i] && !vc.D_pause[dest_of[i]] && reset_L;
    end
  end

`ifdef ARB_WRR_EN
  logic [PTR_W-1:0]    ptr_q, ptr_d, cand;
  logic [WEIGHT_W-1:0] credit_q, credit_d, reload;

  // Stay on ptr while it has credit; otherwise take the first eligible VC after ptr and reload.
  always_comb begin : wrr_pick
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    ptr_d       = ptr_q;
    credit_d    = credit_q;
    reload      = '0;
    cand        = '0;
    if (eligible[ptr_q] && credit_q != '0) begin
      grant_valid = 1'b1;
      credit_d    = credit_q - WEIGHT_W'(1);
    end else begin
      for (int off = NUM_VC; off >= 1; off--) begin
        cand = PTR_W'((int'(ptr_q) + off) % int'(NUM_VC));
        if (eligible[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
      if (grant_valid) begin
        ptr_d    = grant_idx;
        reload   = vc.VC_weight[grant_idx*WEIGHT_W +: WEIGHT_W];
        credit_d = (reload == '0) ? '0 : reload - WEIGHT_W'(1);
      end
    end
  end
`else
  logic unused_weight;
  assign unused_weight = ^vc.VC_weight;

  // Lowest-index eligible VC wins.
  always_comb begin : prio_pick
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(i);
      end
    end
  end
`endif

  always_comb begin : grant_mux
    grant_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (grant_idx == PTR_W'(i)) grant_data = vc.VC_data[i*DATA_W +: DATA_W];
    end
    grant_dest = grant_data[DEST_LSB +: DEST_W];
  end

  always_comb begin : pop_strobe
    vc.VC_pop = '0;
    if (grant_valid) vc.VC_pop[grant_idx] = 1'b1;
  end

  // Granted word lands in its lane; other lanes hold their last word.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d_data_q  <= '0;
      d_valid_q <= '0;
`ifdef ARB_WRR_EN
      ptr_q     <= PTR_W'(NUM_VC - 1);
      credit_q  <= '0;
`endif
    end else begin
      d_valid_q <= '0;
      for (int k = 0; k < NUM_DEST; k++) begin
        if (grant_valid && grant_dest == DEST_W'(k)) begin
          d_data_q[k*DATA_W +: DATA_W] <= grant_data;
          d_valid_q[k]                 <= 1'b1;
        end
      end
`ifdef ARB_WRR_EN
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
`endif
    end
  end

  assign vc.D_data  = d_data_q;
  assign vc.D_valid = d_valid_q;
endmodule

// File: tb/tb_arbitro_vc_param.sv
// Scoreboard bench for arbitro_vc_param: FIFO/queue reference model, randomized traffic, directed corner cases.
module tb_arbitro_vc_param;
  localparam int unsigned DATA_W   = 6;
  localparam int unsigned NUM_VC   = 4;
  localparam int unsigned NUM_DEST = 2;
  localparam int unsigned DEST_LSB = 4;
  localparam int unsigned WEIGHT_W = 3;
  localparam int unsigned DEST_W   = $clog2(NUM_DEST);

  typedef struct {
    logic [NUM_DEST-1:0]        valid;
    logic [NUM_DEST*DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  arbitro_vc_param_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST), .WEIGHT_W(WEIGHT_W)) vc_if ();

  arbitro_vc_param #(
    .DATA_W(DATA_W), .NUM_VC(NUM_VC), .NUM_DEST(NUM_DEST), .DEST_LSB(DEST_LSB), .WEIGHT_W(WEIGHT_W)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .vc(vc_if)
  );

  logic [DATA_W-1:0] fifo [NUM_VC][$];
  logic [DATA_W-1:0] m_lane [NUM_DEST];
  int                weight [NUM_VC];
  logic [NUM_DEST-1:0] pause;
  int   m_ptr, m_credit;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dest_of(input logic [DATA_W-1:0] w);
    return int'(w[DEST_LSB +: DEST_W]);
  endfunction

  // Present FIFO heads, empties, weights and pause to the DUT.
  task automatic drive();
    for (int i = 0; i < NUM_VC; i++) begin
      vc_if.VC_empty[i] = (fifo[i].size() == 0);
      vc_if.VC_data[i*DATA_W +: DATA_W] = (fifo[i].size() != 0) ? fifo[i][0] : DATA_W'($urandom);
      vc_if.VC_weight[i*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(weight[i]);
    end
    vc_if.D_pause = pause;
  endtask

  function automatic bit is_elig(input int i);
    if (fifo[i].size() == 0) return 0;
    return !pause[dest_of(fifo[i][0])];
  endfunction

  function automatic int model_grant();
`ifdef ARB_WRR_EN
    if (is_elig(m_ptr) && m_credit > 0) return m_ptr;
    for (int off = 1; off <= NUM_VC; off++) begin
      if (is_elig((m_ptr + off) % NUM_VC)) return (m_ptr + off) % NUM_VC;
    end
    return -1;
`else
    for (int i = 0; i < NUM_VC; i++) if (is_elig(i)) return i;
    return -1;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = NUM_VC - 1;
    m_credit = 0;
    for (int k = 0; k < NUM_DEST; k++) m_lane[k] = '0;
    sb.delete();
  endtask

  // One cycle, starting at a negedge: drive, check pop, advance the model, push expectation.
  task automatic step(output int g);
    logic [DATA_W-1:0] w;
    exp_t e;
    int d;
    drive();
    #1;
    g = model_grant();
    check("vc_pop", 64'(vc_if.VC_pop), (g >= 0) ? (64'd1 << g) : 64'd0);
    if (g >= 0) begin
      w = fifo[g].pop_front();
      d = dest_of(w);
      m_lane[d] = w;
      e.valid = '0;
      e.valid[d] = 1'b1;
      for (int k = 0; k < NUM_DEST; k++) e.data[k*DATA_W +: DATA_W] = m_lane[k];
      sb.push_back(e);
      if (g == m_ptr && m_credit > 0) m_credit--;
      else begin
        m_ptr = g;
        m_credit = (weight[g] == 0) ? 0 : weight[g] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset_L = 1'b0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      drive();
      #1;
      check("rst_pop", 64'(vc_if.VC_pop), 64'd0);
      check("rst_valid", 64'(vc_if.D_valid), 64'd0);
      check("rst_data", 64'(vc_if.D_data), 64'd0);
      @(negedge clk);
    end
    reset_L = 1'b1;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NUM_VC; i++) fifo[i].delete();
  endtask

  // Monitor: every presented word must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_L === 1'b1 && vc_if.D_valid !== '0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got D_valid=%0h, expected none", vc_if.D_valid);
        end else begin
          e = sb.pop_front();
          check("d_valid", 64'(vc_if.D_valid), 64'(e.valid));
          check("d_data", 64'(vc_if.D_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int seq[$];
    int exp6[6];
    int exp3[3];
`ifdef ARB_WRR_EN
    exp6 = '{0, 0, 1, 0, 0, 1};
    exp3 = '{0, 0, 1};
`else
    exp6 = '{0, 0, 0, 0, 0, 0};
    exp3 = '{0, 0, 0};
`endif
    for (int i = 0; i < NUM_VC; i++) weight[i] = 1;
    pause = '0;
    for (int i = 0; i < NUM_VC; i++) fifo[i].push_back(DATA_W'($urandom));
    reset_L = 1'b0;
    @(negedge clk);
    do_reset(3);
    clear_fifos();

    // Strict/first grant: only VC0 holds a word.
    fifo[0].push_back(6'b100101);
    step(g);
    check("tp_first_grant", 64'(g), 64'd0);
    // Pause skip: dest0 paused, VC1 to dest1 goes.
    fifo[0].push_back(6'b100101);
    fifo[1].push_back(6'b110110);
    pause = 2'b01;
    step(g);
    check("tp_pause_skip", 64'(g), 64'd1);
    pause = '0;
    // All empty: nothing popped, lanes hold.
    clear_fifos();
    step(g);
    check("tp_all_empty", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
    step(g);

    // Weighted sequence from a fresh reset.
    do_reset(1);
    weight[0] = 2;
    weight[1] = 1;
    for (int n = 0; n < 12; n++) begin
      fifo[0].push_back(DATA_W'($urandom));
      fifo[1].push_back(DATA_W'($urandom));
    end
    seq.delete();
    for (int n = 0; n < 6; n++) begin step(g); seq.push_back(g); end
    for (int n = 0; n < 6; n++) check($sformatf("wrr_seq%0d", n), 64'(seq[n]), 64'(exp6[n]));

    // Reset in the middle of a burst.
    do_reset(1);
    step(g);
    step(g);
    #2;
    reset_L = 1'b0;
    #1;
    check("mid_rst_pop", 64'(vc_if.VC_pop), 64'd0);
    check("mid_rst_valid", 64'(vc_if.D_valid), 64'd0);
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    seq.delete();
    for (int n = 0; n < 3; n++) begin step(g); seq.push_back(g); end
    for (int n = 0; n < 3; n++) check($sformatf("post_rst_seq%0d", n), 64'(seq[n]), 64'(exp3[n]));

    // Randomized traffic with random pause and weights.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0)
        for (int i = 0; i < NUM_VC; i++) weight[i] = int'($urandom_range(0, 7));
      for (int i = 0; i < NUM_VC; i++)
        if ($urandom_range(0, 2) == 0 && fifo[i].size() < 4) fifo[i].push_back(DATA_W'($urandom));
      pause = ($urandom_range(0, 2) == 0) ? NUM_DEST'($urandom) : '0;
      step(g);
    end

    pause = '0;
    clear_fifos();
    step(g);
    step(g);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
